popcount_cfu_pipe: RTL and testbench
====================================

// Module: popcount_cfu_pipe
//
// PURPOSE
//  Level-2 (pipelined, handshaked) popcount CFU, generalised from the 32b combinational CFU.
//  Counts set bits in a CFU_XLEN-bit operand and keeps one running accumulator.
//  Functions: plain popcount, popcount-accumulate, accumulator read-and-clear.
//  Sits behind the CPU's CFU request/response port; two-stage pipe, full backpressure.
//
// PARAMETERS
//  CFU_XLEN     32  operand/result width (legal: 6..128); popcount zero-extended to it
//  CFU_FUNC_W   2   width of req_function_id
//
// PORTS
//  clk              in   1           sole clock, all state on rising edge
//  rst              in   1           synchronous, active-high reset
//  req_valid        in   1           request offered
//  req_ready        out  1           request accepted when req_valid&&req_ready
//  req_function_id  in   CFU_FUNC_W  0=POPCNT 1=POPCNT_ACC 2=ACC_CLR 3=reserved
//  req_data         in   CFU_XLEN    operand (ignored for ACC_CLR)
//  resp_valid       out  1           result available
//  resp_ready       in   1           consumer takes result when resp_valid&&resp_ready
//  resp_data        out  CFU_XLEN    result
//  resp_err         out  1           only with CFU_POPCOUNT_ERR_EN (see CONFIGURATION)
//
// BEHAVIOUR
//  - Reset: s1_valid=0, resp_valid=0, resp_data=0, acc=0, resp_err=0; in-flight ops dropped.
//  - Stall = resp_valid && !resp_ready. req_ready = !stall (combinational). On stall no
//    pipe register, acc, or output changes; resp_data held stable while resp_valid.
//  - S1 (on accept): operand split into G=ceil(CFU_XLEN/6) 6-bit groups (top group
//    zero-padded); each 6:3 compressed; G x 3b counts, func id, s1_valid registered.
//  - S2: pc = sum of G counts, width PCW=$clog2(CFU_XLEN+1), zero-extended to CFU_XLEN.
//      POPCNT:     resp_data=pc; acc unchanged
//      POPCNT_ACC: acc<=acc+pc (mod 2^CFU_XLEN, wraps silently); resp_data=new acc
//      ACC_CLR:    resp_data=old acc; acc<=0
//      reserved:   resp_data=0; acc unchanged
//  - Latency: accepted in cycle N -> resp_valid in cycle N+2 (no stall). Throughput 1/cycle.
//  - Back-to-back POPCNT_ACC: acc updated in S2 in issue order; each sees all prior ops.
//  - S2 fires when s1_valid && !stall; resp_valid<=s1_valid when !stall; if resp handshake
//    and no S1 op in same cycle, resp_valid<=0.
//  - Accept and response handshakes in the same cycle are legal and lossless.
//  - Reset mid-operation overrides all: pipe flushed, acc cleared, no response emitted.
//
// CONFIGURATION
//  CFU_POPCOUNT_ERR_EN defined: resp_err port exists; =1 with resp_valid for reserved id
//    (resp_data=0), else 0; registered alongside resp_data, 0 at reset.
//  Not defined: port absent; reserved id silently returns 0.
//
// STRUCTURE
//  - cfu_pkg: function-id localparams (CFU_POPCNT=0, CFU_POPCNT_ACC=1, CFU_ACC_CLR=2),
//    CFU_FUNC_W; shared with other CFUs.
//  - Sub-module compress63: 6-bit in -> 3-bit count (64x3 ROM, three 6-LUTs), generate-
//    instantiated G times in S1. S2 adder tree and acc stay in top module.
//
// TESTING
//  1. CFU_XLEN=32, POPCNT 0xFFFF_FFFF -> resp_data=32 exactly 2 cycles after accept; 0x0 -> 0.
//  2. POPCNT_ACC 0x0000_00FF, 0xF000_000F, 0x1 then ACC_CLR -> 8,16,17 then 17; next ACC_CLR -> 0.
//  3. Stream 8 POPCNTs, resp_ready low cycles 3-6 -> req_ready low same cycles, resp_data
//     stable, all 8 results in order, none lost/duplicated.
//  4. CFU_XLEN=64: POPCNT 0xFFFF_FFFF_FFFF_FFFF -> 64; 0x8000_0000_0000_0001 -> 2 (padded group).
//  5. acc=0xFFFF_FFFF, POPCNT_ACC 0x3 -> resp_data=0x1 (wrap); rst pulsed with two ops in
//     flight -> resp_valid=0 next cycle, ACC_CLR returns 0.
//  6. ERR_EN build: id 3 with req_data=0xFF -> resp_data=0, resp_err=1; POPCNT -> resp_err=0.

Source files
------------

// File: rtl/cfu_pkg.sv
// cfu_pkg: definitions shared by the CFU family.
//   CFU_FUNC_W      default width of req_function_id
//   CFU_POPCNT      plain popcount
//   CFU_POPCNT_ACC  popcount added into the running accumulator
//   CFU_ACC_CLR     return the accumulator and clear it
//   popcnt6()       6-bit population count, the contents of the 64x3 compressor ROM
package cfu_pkg;

  localparam int unsigned CFU_FUNC_W = 2;

  localparam logic [CFU_FUNC_W-1:0] CFU_POPCNT     = 2'd0;
  localparam logic [CFU_FUNC_W-1:0] CFU_POPCNT_ACC = 2'd1;
  localparam logic [CFU_FUNC_W-1:0] CFU_ACC_CLR    = 2'd2;

  function automatic logic [2:0] popcnt6(input logic [5:0] v);
    logic [2:0] c;
    c = '0;
    for (int unsigned i = 0; i < 6; i++) begin
      c = c + {2'b00, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/popcount_cfu_pipe_compress63.sv
// compress63: 6:3 compressor, the number of set bits in a 6-bit group.
// Purely combinational; each output bit depends on all six inputs.
//   in_i   [5:0]  input group
//   cnt_o  [2:0]  number of ones in in_i (0..6)
module compress63
  import cfu_pkg::*;
(
  input  logic [5:0] in_i,
  output logic [2:0] cnt_o
);

  always_comb begin
    cnt_o = popcnt6(in_i);
  end

endmodule

// File: rtl/popcount_cfu_pipe.sv
// popcount_cfu_pipe: two-stage, fully back-pressured popcount CFU with one
// running accumulator.
//   S1 (on accept): operand split into 6-bit groups, each compressed to a 3-bit count.
//   S2: counts summed, function applied, result and accumulator registered.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_ready           request handshake
//   req_function_id               0=POPCNT 1=POPCNT_ACC 2=ACC_CLR 3=reserved
//   req_data                      operand (ignored for ACC_CLR)
//   resp_valid/resp_ready         response handshake
//   resp_data                     result
//   resp_err                      present only when CFU_POPCOUNT_ERR_EN is defined;
//                                 flags a response to a reserved function id
module popcount_cfu_pipe #(
  parameter int unsigned CFU_XLEN   = 32,
  parameter int unsigned CFU_FUNC_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [CFU_FUNC_W-1:0] req_function_id,
  input  logic [CFU_XLEN-1:0]   req_data,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [CFU_XLEN-1:0]   resp_data
`ifdef CFU_POPCOUNT_ERR_EN
  ,
  output logic                  resp_err
`endif
);

  import cfu_pkg::*;

  localparam int unsigned G    = (CFU_XLEN + 5) / 6;
  localparam int unsigned PADW = G * 6;
  localparam int unsigned PCW  = $clog2(CFU_XLEN + 1);

  logic                  stall;
  logic                  accept;
  logic                  s2_fire;

  logic [PADW-1:0]       op_pad;
  logic [G-1:0][2:0]     grp_cnt;

  logic                  s1_valid_q;
  logic [CFU_FUNC_W-1:0] s1_func_q;
  logic [G-1:0][2:0]     s1_cnt_q;

  logic [PCW-1:0]        pc;
  logic [CFU_XLEN-1:0]   pc_ext;

  logic                  resp_valid_q;
  logic [CFU_XLEN-1:0]   resp_data_q, resp_data_d;
  logic [CFU_XLEN-1:0]   acc_q, acc_d;
`ifdef CFU_POPCOUNT_ERR_EN
  logic                  resp_err_q, resp_err_d;
`endif

  // One global stall freezes every stage, so req_ready is just its inverse.
  assign stall     = resp_valid_q && !resp_ready;
  assign req_ready = !stall;
  assign accept    = req_valid && req_ready;
  assign s2_fire   = s1_valid_q && !stall;

  // Zero-pad the operand up to whole 6-bit groups.
  assign op_pad = PADW'(req_data);

  for (genvar g = 0; g < G; g++) begin : g_cmp
    compress63 u_cmp (
      .in_i  (op_pad[g*6 +: 6]),
      .cnt_o (grp_cnt[g])
    );
  end

  always_comb begin
    pc = '0;
    for (int unsigned g = 0; g < G; g++) begin
      pc = pc + PCW'(s1_cnt_q[g]);
    end
  end

  assign pc_ext = CFU_XLEN'(pc);

  always_comb begin
    acc_d       = acc_q;
    resp_data_d = resp_data_q;
`ifdef CFU_POPCOUNT_ERR_EN
    resp_err_d  = resp_err_q;
`endif
    if (s2_fire) begin
`ifdef CFU_POPCOUNT_ERR_EN
      resp_err_d = 1'b0;
`endif
      case (s1_func_q)
        CFU_FUNC_W'(CFU_POPCNT): begin
          resp_data_d = pc_ext;
        end
        CFU_FUNC_W'(CFU_POPCNT_ACC): begin
          acc_d       = acc_q + pc_ext;
          resp_data_d = acc_d;
        end
        CFU_FUNC_W'(CFU_ACC_CLR): begin
          resp_data_d = acc_q;
          acc_d       = '0;
        end
        default: begin
          resp_data_d = '0;
`ifdef CFU_POPCOUNT_ERR_EN
          resp_err_d  = 1'b1;
`endif
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_func_q    <= '0;
      s1_cnt_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      acc_q        <= '0;
`ifdef CFU_POPCOUNT_ERR_EN
      resp_err_q   <= 1'b0;
`endif
    end else if (!stall) begin
      // An un-stalled cycle always drains S1 into S2, so S1 validity simply
      // follows the accept, and the response slot follows S1.
      s1_valid_q   <= accept;
      if (accept) begin
        s1_func_q <= req_function_id;
        s1_cnt_q  <= grp_cnt;
      end
      resp_valid_q <= s1_valid_q;
      resp_data_q  <= resp_data_d;
      acc_q        <= acc_d;
`ifdef CFU_POPCOUNT_ERR_EN
      resp_err_q   <= resp_err_d;
`endif
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
`ifdef CFU_POPCOUNT_ERR_EN
  assign resp_err   = resp_err_q;
`endif

endmodule

// File: tb/tb_popcount_cfu_pipe.sv
// Directed bench for popcount_cfu_pipe. Three instances (32-, 64- and 6-bit
// operands) share one request bus and run in lockstep; each check picks the
// instance whose width exercises the case at hand.
module tb_popcount_cfu_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [1:0]  req_function_id;
  logic [63:0] req_data;
  logic        resp_ready;

  logic        req_ready32, req_ready64, req_ready6;
  logic        resp_valid32, resp_valid64, resp_valid6;
  logic [31:0] resp_data32;
  logic [63:0] resp_data64;
  logic [5:0]  resp_data6;
`ifdef CFU_POPCOUNT_ERR_EN
  logic        err32, err64, err6;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] r32;
  logic [63:0] r64;
  logic [5:0]  r6;

  always #5 clk = ~clk;

  popcount_cfu_pipe #(.CFU_XLEN(32), .CFU_FUNC_W(2)) u_dut (
    .clk (clk), .rst (rst),
    .req_valid (req_valid), .req_ready (req_ready32),
    .req_function_id (req_function_id), .req_data (req_data[31:0]),
    .resp_valid (resp_valid32), .resp_ready (resp_ready),
    .resp_data (resp_data32)
`ifdef CFU_POPCOUNT_ERR_EN
    , .resp_err (err32)
`endif
  );

  popcount_cfu_pipe #(.CFU_XLEN(64), .CFU_FUNC_W(2)) u_dut64 (
    .clk (clk), .rst (rst),
    .req_valid (req_valid), .req_ready (req_ready64),
    .req_function_id (req_function_id), .req_data (req_data),
    .resp_valid (resp_valid64), .resp_ready (resp_ready),
    .resp_data (resp_data64)
`ifdef CFU_POPCOUNT_ERR_EN
    , .resp_err (err64)
`endif
  );

  popcount_cfu_pipe #(.CFU_XLEN(6), .CFU_FUNC_W(2)) u_dut6 (
    .clk (clk), .rst (rst),
    .req_valid (req_valid), .req_ready (req_ready6),
    .req_function_id (req_function_id), .req_data (req_data[5:0]),
    .resp_valid (resp_valid6), .resp_ready (resp_ready),
    .resp_data (resp_data6)
`ifdef CFU_POPCOUNT_ERR_EN
    , .resp_err (err6)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one request at a negedge with resp_ready high and return at the
  // negedge where the response is visible; latency counts rising edges.
  task automatic do_op(input logic [1:0] f, input logic [63:0] d);
    int lat;
    req_valid       = 1'b1;
    req_function_id = f;
    req_data        = d;
    resp_ready      = 1'b1;
    #1;
    check("op_req_ready", req_ready32, 1);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    req_valid = 1'b0;
    while (!resp_valid32 && lat < 8) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("op_latency", lat, 2);
    check("op_valid64", resp_valid64, 1);
    check("op_valid6", resp_valid6, 1);
    r32 = resp_data32;
    r64 = resp_data64;
    r6  = resp_data6;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  logic [31:0] sv [8];
  logic [31:0] se [8];

  initial begin
    int issued;
    int rx;
    sv = '{32'h1, 32'h3, 32'h7, 32'hF, 32'hFF, 32'hFFFF, 32'h8000_0000, 32'hAAAA_AAAA};
    se = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd8, 32'd16, 32'd1, 32'd16};

    rst = 1'b1; req_valid = 1'b0; req_function_id = '0; req_data = '0; resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_resp_valid", resp_valid32, 0);
    check("rst_resp_data", resp_data32, 0);
    check("rst_req_ready", req_ready32, 1);
    @(negedge clk);

    // Plain popcount, extremes.
    do_op(2'd0, 64'hFFFF_FFFF);         check("pc_all_ones", r32, 32);
    do_op(2'd0, 64'h0);                 check("pc_zero", r32, 0);

    // Accumulate then read-and-clear.
    do_op(2'd1, 64'h0000_00FF);         check("acc_1", r32, 8);
    do_op(2'd1, 64'hF000_000F);         check("acc_2", r32, 16);
    do_op(2'd1, 64'h1);                 check("acc_3", r32, 17);
    do_op(2'd2, 64'h0);                 check("clr_1", r32, 17);
    do_op(2'd2, 64'h0);                 check("clr_2", r32, 0);

    // POPCNT and reserved leave acc alone.
    do_op(2'd0, 64'hFF);                check("pc_ff", r32, 8);
    do_op(2'd1, 64'h1);                 check("acc_after_pc", r32, 1);
    do_op(2'd3, 64'hFF);                check("rsvd_data", r32, 0);
`ifdef CFU_POPCOUNT_ERR_EN
    check("rsvd_err", err32, 1);
`endif
    do_op(2'd1, 64'h1);                 check("acc_after_rsvd", r32, 2);
`ifdef CFU_POPCOUNT_ERR_EN
    check("acc_err", err32, 0);
`endif
    do_op(2'd0, 64'h1);                 check("pc_one", r32, 1);
`ifdef CFU_POPCOUNT_ERR_EN
    check("pc_err", err32, 0);
`endif
    do_op(2'd2, 64'h0);                 check("clr_3", r32, 2);

    // Wide operand and the padded top group.
    do_op(2'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    check("w64_all", r64, 64);
    check("w6_all", r6, 6);
    do_op(2'd0, 64'h8000_0000_0000_0001);
    check("w64_pad", r64, 2);
    check("w32_low", r32, 1);
    check("w6_low", r6, 1);

    // Accumulator wrap on the 6-bit instance (mod 64); 32-bit one does not wrap.
    do_op(2'd2, 64'h0);
    for (int i = 0; i < 10; i++) do_op(2'd1, 64'h3F);
    check("w6_acc60", r6, 60);
    do_op(2'd1, 64'h7);                 check("w6_acc63", r6, 63);
    do_op(2'd1, 64'h3);                 check("w6_wrap", r6, 1);
    check("w32_nowrap", r32, 65);

    // Reset with two accumulates in flight.
    req_valid = 1'b1; req_function_id = 2'd1; req_data = 64'hFF; resp_ready = 1'b1;
    @(negedge clk);
    req_data = 64'hFF;
    @(negedge clk);
    rst = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_valid", resp_valid32, 0);
    check("midrst_data", resp_data32, 0);
    @(negedge clk);
    check("midrst_valid_later", resp_valid32, 0);
    do_op(2'd2, 64'h0);                 check("midrst_acc", r32, 0);

    // Drain, then stream 8 POPCNTs with resp_ready low in cycles 3..6.
    resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    issued = 0;
    rx     = 0;
    for (int k = 0; k < 40 && rx < 8; k++) begin
      resp_ready      = !(k >= 3 && k <= 6);
      req_valid       = (issued < 8);
      req_function_id = 2'd0;
      req_data        = {32'h0, sv[(issued < 8) ? issued : 0]};
      #1;
      if (k <= 8) check("stream_req_ready", req_ready32, (k >= 3 && k <= 6) ? 0 : 1);
      if (resp_valid32) begin
        check("stream_data", resp_data32, se[rx]);
        if (resp_ready) rx++;
      end
      if (req_valid && req_ready32) issued++;
      @(negedge clk);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    check("stream_count", rx, 8);
    check("stream_issued", issued, 8);
    repeat (2) @(negedge clk);
    check("stream_no_extra", resp_valid32, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
